// File: rtl/score_seg7_scan_pkg.sv
// score_seg7_scan_pkg
//   Shared constants for the score display scanner: active-low segment
//   patterns ({g,f,e,d,c,b,a}), anode-off pattern, digit count and the
//   scan slot enumeration with its sequencing helpers.
package score_seg7_scan_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [3:0] AN_OFF = 4'hF;

  // One slot per displayed digit; slot index equals the anode position
  typedef enum logic [1:0] {
    SLOT_ONES     = 2'd0,
    SLOT_TENS     = 2'd1,
    SLOT_HUNDREDS = 2'd2
  } slot_t;

  // Scan order is ones -> tens -> hundreds -> ones
  function automatic slot_t nextSlot(input slot_t cur);
    case (cur)
      SLOT_ONES:     nextSlot = SLOT_TENS;
      SLOT_TENS:     nextSlot = SLOT_HUNDREDS;
      default:       nextSlot = SLOT_ONES;
    endcase
  endfunction

  // Active-low anode enable for a slot; the fourth digit is never driven
  function automatic logic [3:0] slotAnode(input slot_t s);
    case (s)
      SLOT_ONES:     slotAnode = 4'b1110;
      SLOT_TENS:     slotAnode = 4'b1101;
      SLOT_HUNDREDS: slotAnode = 4'b1011;
      default:       slotAnode = AN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/score_seg7_scan_if.sv
// score_seg7_scan_if
//   Bundles the score input and display output signals of the scanner.
//   master: score source / board side (drives bcd_in, blank_lz, blink_en)
//   slave : scanner (drives an, seg, dp, frame_tick)
//   bcd_in     [11:8] hundreds, [7:4] tens, [3:0] ones
//   blank_lz   suppress leading zeros
//   blink_en   flash display
//   an         anode enables, active-low
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   frame_tick one-cycle pulse when a new score snapshot is taken
interface score_seg7_scan_if;
  import score_seg7_scan_pkg::*;

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    blank_lz;
  logic                    blink_en;
  logic [3:0]              an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_tick;

  modport master (
    output bcd_in, blank_lz, blink_en,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  bcd_in, blank_lz, blink_en,
    output an, seg, dp, frame_tick
  );

endinterface

// File: rtl/score_seg7_scan_seg7_decoder.sv
// seg7_decoder
//   Purely combinational BCD nibble to active-low 7-segment pattern.
//   i_nibble  4-bit digit; 10..15 are not decimal digits and show a dash
//   o_seg     {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import score_seg7_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Table lookup; anything outside 0..9 is flagged visibly as a dash
  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_seg7_scan.sv
// score_seg7_scan
//   Time-multiplexes a 3-digit BCD score onto a 4-digit common-anode
//   7-segment display. The score is captured once per scan frame so a
//   frame never mixes old and new digits. Supports leading-zero blanking
//   and blinking. All display outputs are registered.
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   slave side of score_seg7_scan_if (bcd_in, blank_lz, blink_en in;
//         an, seg, dp, frame_tick out)
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   BLINK_FRAMES  scan frames per blink phase (>= 1)
module score_seg7_scan
  import score_seg7_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic               clk,
  input  logic               rst,
  score_seg7_scan_if.slave   bus
);

  localparam int DIV_W   = $clog2(REFRESH_DIV);
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0]        r_divCnt;
  slot_t                   r_slot;
  slot_t                   w_slotNext;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [BLINK_W-1:0]      r_blinkCnt;
  logic                    r_phase;
  logic                    r_loadPend;
  logic [3:0]              r_an;
  logic [6:0]              r_seg;
  logic                    r_frameTick;

  logic                    w_divWrap;
  logic                    w_load;
  logic [3:0]              w_nibble;
  logic [6:0]              w_digitSeg;
  logic [3:0]              w_anNext;
  logic [6:0]              w_segNext;
  logic                    w_hundredsZero;
  logic                    w_tensZero;
  logic                    w_blanked;
  logic                    w_dark;

  assign w_divWrap = (r_divCnt == DIV_W'(REFRESH_DIV - 1));

  // A snapshot is taken on the first cycle out of reset and whenever the
  // last slot of a frame hands over to the first, so a whole frame always
  // shows one consistent score.
  assign w_load = r_loadPend | (w_divWrap & (r_slot == SLOT_HUNDREDS));

  // Refresh divider: sets how long each digit stays lit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divCnt <= '0;
    end else if (w_divWrap) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end

  // Slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot <= SLOT_ONES;
    end else begin
      r_slot <= w_slotNext;
    end
  end

  // Slot next-state: move to the next digit each time the divider wraps
  always_comb begin
    w_slotNext = r_slot;
    if (w_divWrap) begin
      w_slotNext = nextSlot(r_slot);
    end
  end

  // Snapshot register and frame pulse; the pending flag only covers the
  // very first cycle after reset so the display never starts empty-handed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow    <= '0;
      r_loadPend  <= 1'b1;
      r_frameTick <= 1'b0;
    end else begin
      r_loadPend  <= 1'b0;
      r_frameTick <= w_load;
      if (w_load) begin
        r_shadow <= bus.bcd_in;
      end
    end
  end

  // Blink counter: counts frames and flips the visible/dark phase every
  // BLINK_FRAMES frames. It runs whether or not blinking is enabled so
  // enabling blink picks up a steady rhythm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blinkCnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_load) begin
      if (r_blinkCnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        r_blinkCnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_blinkCnt <= r_blinkCnt + 1'b1;
      end
    end
  end

  // Digit select for the current slot
  always_comb begin
    w_nibble = r_shadow[3:0];
    case (r_slot)
      SLOT_ONES:     w_nibble = r_shadow[3:0];
      SLOT_TENS:     w_nibble = r_shadow[7:4];
      SLOT_HUNDREDS: w_nibble = r_shadow[11:8];
      default:       w_nibble = r_shadow[3:0];
    endcase
  end

  seg7_decoder u_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_digitSeg)
  );

  assign w_hundredsZero = (r_shadow[11:8] == 4'd0);
  assign w_tensZero     = (r_shadow[7:4] == 4'd0);

  // Slot output logic. Tens is only a leading zero when hundreds is also
  // zero; ones always shows so a zero score reads "0". Invalid nibbles are
  // non-zero and therefore never blanked.
  always_comb begin
    w_blanked = 1'b0;
    if (bus.blank_lz) begin
      case (r_slot)
        SLOT_HUNDREDS: w_blanked = w_hundredsZero;
        SLOT_TENS:     w_blanked = w_hundredsZero & w_tensZero;
        default:       w_blanked = 1'b0;
      endcase
    end
    w_dark = bus.blink_en & r_phase;
    if (w_blanked | w_dark) begin
      w_anNext  = AN_OFF;
      w_segNext = SEG_BLANK;
    end else begin
      w_anNext  = slotAnode(r_slot);
      w_segNext = w_digitSeg;
    end
  end

  // Registered display drive for glitch-free pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_anNext;
      r_seg <= w_segNext;
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = 1'b1;
  assign bus.frame_tick = r_frameTick;

endmodule

// File: tb/tb_score_seg7_scan.sv
// tb_score_seg7_scan
//   Scoreboard bench for score_seg7_scan with REFRESH_DIV=4, BLINK_FRAMES=2.
//   The stimulus process predicts each clock edge's display from a cycle
//   index model (slot = edge / slot length, snapshots every frame, blink
//   phase from the number of frames seen) and queues it; the monitor pops
//   and compares one entry per clock edge.
module tb_score_seg7_scan;

  localparam int R     = 4;
  localparam int BF    = 2;
  localparam int FRAME = 3 * R;

  typedef struct {
    int         edgeIdx;
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  exp_t       expQ[$];
  int         testsRun    = 0;
  int         testsFailed = 0;
  int         edgeNum     = 0;
  logic [11:0] mShadow    = '0;
  int         mLoads      = 0;
  logic [6:0] segTable [16];

  always #5 clk = ~clk;

  score_seg7_scan_if bus ();

  score_seg7_scan #(
    .REFRESH_DIV  (R),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // One comparison; counts it and reports a mismatch
  task automatic checkOutput(input string name, input int edgeIdx,
                             input logic [31:0] got, input logic [31:0] want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeIdx, got, want);
    end
  endtask

  function automatic logic [11:0] randomBcd();
    logic [11:0] v;
    for (int d = 0; d < 3; d++) begin
      if ($urandom_range(0, 2) == 0) v[d*4 +: 4] = 4'd0;
      else v[d*4 +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  // Predict the display after the next rising edge from the inputs as they
  // stand now, then account for a snapshot taken on that edge
  task automatic modelEdge();
    exp_t       e;
    int         slot;
    logic [3:0] dig;
    bit         isLoad;
    bit         dark;
    bit         blanked;
    edgeNum++;
    isLoad  = (edgeNum == 1) || (edgeNum % FRAME == 0);
    slot    = ((edgeNum - 1) / R) % 3;
    dig     = mShadow[slot*4 +: 4];
    dark    = bus.blink_en && (((mLoads / BF) % 2) == 1);
    blanked = bus.blank_lz &&
              ((slot == 2 && mShadow[11:8] == 4'd0) ||
               (slot == 1 && mShadow[11:8] == 4'd0 && mShadow[7:4] == 4'd0));
    e.edgeIdx = edgeNum;
    e.tick    = isLoad;
    if (dark || blanked) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
    end else begin
      e.an  = ~(4'(1) << slot);
      e.seg = segTable[dig];
    end
    expQ.push_back(e);
    if (isLoad) begin
      mShadow = bus.bcd_in;
      mLoads++;
    end
  endtask

  // Called at a falling edge; returns at a falling edge
  task automatic applyStimulus(input int cycles, input bit randomize);
    for (int c = 0; c < cycles; c++) begin
      if (randomize) begin
        if ($urandom_range(0, 7) == 0)  bus.bcd_in   = randomBcd();
        if ($urandom_range(0, 29) == 0) bus.blank_lz = ~bus.blank_lz;
        if ($urandom_range(0, 39) == 0) bus.blink_en = ~bus.blink_en;
      end
      modelEdge();
      @(negedge clk);
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must go idle at once
  task automatic resetDut();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_an",   -1, 32'(bus.an),         32'h0000000F);
    checkOutput("rst_seg",  -1, 32'(bus.seg),        32'h0000007F);
    checkOutput("rst_dp",   -1, 32'(bus.dp),         32'h00000001);
    checkOutput("rst_tick", -1, 32'(bus.frame_tick), 32'h00000000);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    edgeNum = 0;
    mShadow = '0;
    mLoads  = 0;
  endtask

  // Monitor: one expected entry per clock edge while out of reset
  always @(posedge clk) begin
    #1;
    if (!rst && expQ.size() > 0) begin : popCheck
      exp_t e;
      e = expQ.pop_front();
      checkOutput("an",         e.edgeIdx, 32'(bus.an),         32'(e.an));
      checkOutput("seg",        e.edgeIdx, 32'(bus.seg),        32'(e.seg));
      checkOutput("frame_tick", e.edgeIdx, 32'(bus.frame_tick), 32'(e.tick));
      checkOutput("dp",         e.edgeIdx, 32'(bus.dp),         32'h1);
    end
  end

  initial begin
    segTable = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    bus.bcd_in   = 12'h255;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;

    resetDut();
    applyStimulus(40, 1'b0);

    bus.bcd_in   = 12'h007;
    bus.blank_lz = 1'b1;
    applyStimulus(30, 1'b0);
    bus.blank_lz = 1'b0;
    applyStimulus(24, 1'b0);

    bus.bcd_in   = 12'h000;
    bus.blank_lz = 1'b1;
    applyStimulus(26, 1'b0);

    // Score changes in the middle of the tens slot
    bus.blank_lz = 1'b0;
    bus.bcd_in   = 12'h123;
    resetDut();
    applyStimulus(6, 1'b0);
    bus.bcd_in = 12'h456;
    applyStimulus(30, 1'b0);

    // Blinking, with an invalid ones nibble
    bus.bcd_in   = 12'h12C;
    bus.blink_en = 1'b1;
    applyStimulus(120, 1'b0);
    bus.blink_en = 1'b0;
    applyStimulus(30, 1'b0);

    // Reset while the hundreds slot is being scanned
    bus.bcd_in = 12'h987;
    resetDut();
    applyStimulus(10, 1'b0);
    resetDut();
    applyStimulus(20, 1'b0);

    applyStimulus(800, 1'b1);

    repeat (3) @(negedge clk);
    checkOutput("queue_drain", edgeNum, 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
